// File: rtl/alu_reservation_station_pkg.sv
// Shared constants and types for the ALU reservation station: operand/entry layout
// and the forwarding-bus wakeup rule used both for held entries and at dispatch.
package alu_reservation_station_pkg;

    localparam int DATA_LEN         = 32;
    localparam int RRF_SEL          = 6;
    localparam int ALU_OP_WIDTH     = 4;
    localparam int RS_ALU_ENTRY_NUM = 8;
    localparam int RS_ALU_ENTRY_SEL = 3;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_SLL  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_SLT  = 4'd8,
        ALU_OP_SLTU = 4'd9
    } alu_op_e;

    // While vld is low, the low RRF_SEL bits of data name the producing rename tag.
    typedef struct packed {
        logic                vld;
        logic [DATA_LEN-1:0] data;
    } operand_t;

    typedef struct packed {
        logic                    busy;
        logic [ALU_OP_WIDTH-1:0] op;
        operand_t                src1;
        operand_t                src2;
        logic [RRF_SEL-1:0]      rrf_tag;
        logic                    if_write_rrf;
    } rs_entry_t;

    // Bus 0 takes precedence if both buses carry the awaited tag.
    function automatic operand_t operand_wakeup(
        input operand_t            cur,
        input logic                f0_vld,
        input logic [RRF_SEL-1:0]  f0_tag,
        input logic [DATA_LEN-1:0] f0_data,
        input logic                f1_vld,
        input logic [RRF_SEL-1:0]  f1_tag,
        input logic [DATA_LEN-1:0] f1_data
    );
        operand_t res;
        res = cur;
        if (!cur.vld) begin
            if (f0_vld && (f0_tag == cur.data[RRF_SEL-1:0])) begin
                res.vld  = 1'b1;
                res.data = f0_data;
            end else if (f1_vld && (f1_tag == cur.data[RRF_SEL-1:0])) begin
                res.vld  = 1'b1;
                res.data = f1_data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_reservation_station_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus a
// valid flag; idx_o is zero when no request is set.
module prio_enc_lsb #(
    parameter int WIDTH = 8,
    parameter int SEL   = 3
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [SEL-1:0]   idx_o,
    output logic             vld_o
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = SEL'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are valid,
// snoops two forwarding buses, and issues the lowest-index ready op each cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int ENTRY_NUM = RS_ALU_ENTRY_NUM,
    parameter int ENTRY_SEL = RS_ALU_ENTRY_SEL
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    kill_i,
    input  logic                    dispatch_we_i,
    input  logic [ALU_OP_WIDTH-1:0] dispatch_alu_op_i,
    input  logic [DATA_LEN-1:0]     dispatch_src1_i,
    input  logic                    dispatch_src1_vld_i,
    input  logic [DATA_LEN-1:0]     dispatch_src2_i,
    input  logic                    dispatch_src2_vld_i,
    input  logic [RRF_SEL-1:0]      dispatch_rrf_tag_i,
    input  logic                    dispatch_if_write_rrf_i,
    input  logic                    fwd0_vld_i,
    input  logic [RRF_SEL-1:0]      fwd0_tag_i,
    input  logic [DATA_LEN-1:0]     fwd0_data_i,
    input  logic                    fwd1_vld_i,
    input  logic [RRF_SEL-1:0]      fwd1_tag_i,
    input  logic [DATA_LEN-1:0]     fwd1_data_i,
    output logic                    full_o,
    output logic [ENTRY_SEL:0]      busy_cnt_o,
    output logic                    issue_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [DATA_LEN-1:0]     src1_o,
    output logic [DATA_LEN-1:0]     src2_o,
    output logic [RRF_SEL-1:0]      rrf_tag_o,
    output logic                    if_write_rrf_o
);

    rs_entry_t entry_q [ENTRY_NUM];
    rs_entry_t entry_d [ENTRY_NUM];

    logic [ENTRY_NUM-1:0] busy_vec;
    logic [ENTRY_NUM-1:0] free_vec;
    logic [ENTRY_NUM-1:0] ready_vec;
    logic [ENTRY_SEL-1:0] alloc_idx;
    logic                 alloc_vld;
    logic [ENTRY_SEL-1:0] sel_idx;
    logic                 sel_vld;
    logic [ENTRY_SEL:0]   busy_cnt;

    logic                    issue_q;
    logic [ALU_OP_WIDTH-1:0] alu_op_q;
    logic [DATA_LEN-1:0]     src1_q;
    logic [DATA_LEN-1:0]     src2_q;
    logic [RRF_SEL-1:0]      rrf_tag_q;
    logic                    if_write_rrf_q;

    operand_t disp_src1;
    operand_t disp_src2;

    generate
        for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_vec
            assign busy_vec[gi]  = entry_q[gi].busy;
            assign ready_vec[gi] = entry_q[gi].busy & entry_q[gi].src1.vld & entry_q[gi].src2.vld;
        end
    endgenerate

    assign free_vec = ~busy_vec;

    prio_enc_lsb #(
        .WIDTH (ENTRY_NUM),
        .SEL   (ENTRY_SEL)
    ) u_alloc_enc (
        .req_i (free_vec),
        .idx_o (alloc_idx),
        .vld_o (alloc_vld)
    );

    prio_enc_lsb #(
        .WIDTH (ENTRY_NUM),
        .SEL   (ENTRY_SEL)
    ) u_select_enc (
        .req_i (ready_vec),
        .idx_o (sel_idx),
        .vld_o (sel_vld)
    );

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            busy_cnt = busy_cnt + {{ENTRY_SEL{1'b0}}, busy_vec[i]};
        end
    end

    assign full_o     = &busy_vec;
    assign busy_cnt_o = busy_cnt;

    // Operands arriving on a forwarding bus in the dispatch cycle are captured directly.
    always_comb begin
        disp_src1 = operand_wakeup('{vld: dispatch_src1_vld_i, data: dispatch_src1_i},
                                   fwd0_vld_i, fwd0_tag_i, fwd0_data_i,
                                   fwd1_vld_i, fwd1_tag_i, fwd1_data_i);
        disp_src2 = operand_wakeup('{vld: dispatch_src2_vld_i, data: dispatch_src2_i},
                                   fwd0_vld_i, fwd0_tag_i, fwd0_data_i,
                                   fwd1_vld_i, fwd1_tag_i, fwd1_data_i);
    end

    // Allocation only ever targets a non-busy slot, so it never collides with the
    // entry being issued; the issued slot becomes allocatable one cycle later.
    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].busy) begin
                entry_d[i].src1 = operand_wakeup(entry_q[i].src1,
                                                 fwd0_vld_i, fwd0_tag_i, fwd0_data_i,
                                                 fwd1_vld_i, fwd1_tag_i, fwd1_data_i);
                entry_d[i].src2 = operand_wakeup(entry_q[i].src2,
                                                 fwd0_vld_i, fwd0_tag_i, fwd0_data_i,
                                                 fwd1_vld_i, fwd1_tag_i, fwd1_data_i);
            end
            if (sel_vld && (sel_idx == ENTRY_SEL'(i))) begin
                entry_d[i].busy = 1'b0;
            end
            if (dispatch_we_i && alloc_vld && (alloc_idx == ENTRY_SEL'(i))) begin
                entry_d[i].busy         = 1'b1;
                entry_d[i].op           = dispatch_alu_op_i;
                entry_d[i].src1         = disp_src1;
                entry_d[i].src2         = disp_src2;
                entry_d[i].rrf_tag      = dispatch_rrf_tag_i;
                entry_d[i].if_write_rrf = dispatch_if_write_rrf_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entry_q[i] <= '0;
            end
        end else if (kill_i) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entry_q[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Payload fields hold their last value on idle cycles; only the strobe drops.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            issue_q        <= 1'b0;
            alu_op_q       <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
            rrf_tag_q      <= '0;
            if_write_rrf_q <= 1'b0;
        end else if (kill_i) begin
            issue_q        <= 1'b0;
            alu_op_q       <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
            rrf_tag_q      <= '0;
            if_write_rrf_q <= 1'b0;
        end else if (sel_vld) begin
            issue_q        <= 1'b1;
            alu_op_q       <= entry_q[sel_idx].op;
            src1_q         <= entry_q[sel_idx].src1.data;
            src2_q         <= entry_q[sel_idx].src2.data;
            rrf_tag_q      <= entry_q[sel_idx].rrf_tag;
            if_write_rrf_q <= entry_q[sel_idx].if_write_rrf;
        end else begin
            issue_q        <= 1'b0;
        end
    end

    assign issue_o        = issue_q;
    assign alu_op_o       = alu_op_q;
    assign src1_o         = src1_q;
    assign src2_o         = src2_q;
    assign rrf_tag_o      = rrf_tag_q;
    assign if_write_rrf_o = if_write_rrf_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: an entry-table model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    reset_i = 1'b0;
    logic                    kill_i;
    logic                    dispatch_we_i;
    logic [ALU_OP_WIDTH-1:0] dispatch_alu_op_i;
    logic [DATA_LEN-1:0]     dispatch_src1_i;
    logic                    dispatch_src1_vld_i;
    logic [DATA_LEN-1:0]     dispatch_src2_i;
    logic                    dispatch_src2_vld_i;
    logic [RRF_SEL-1:0]      dispatch_rrf_tag_i;
    logic                    dispatch_if_write_rrf_i;
    logic                    fwd0_vld_i, fwd1_vld_i;
    logic [RRF_SEL-1:0]      fwd0_tag_i, fwd1_tag_i;
    logic [DATA_LEN-1:0]     fwd0_data_i, fwd1_data_i;
    logic                    full_o;
    logic [RS_ALU_ENTRY_SEL:0] busy_cnt_o;
    logic                    issue_o;
    logic [ALU_OP_WIDTH-1:0] alu_op_o;
    logic [DATA_LEN-1:0]     src1_o, src2_o;
    logic [RRF_SEL-1:0]      rrf_tag_o;
    logic                    if_write_rrf_o;

    int n_vec = 0;
    int n_err = 0;

    alu_reservation_station dut (
        .clk_i                   (clk_i),
        .reset_i                 (reset_i),
        .kill_i                  (kill_i),
        .dispatch_we_i           (dispatch_we_i),
        .dispatch_alu_op_i       (dispatch_alu_op_i),
        .dispatch_src1_i         (dispatch_src1_i),
        .dispatch_src1_vld_i     (dispatch_src1_vld_i),
        .dispatch_src2_i         (dispatch_src2_i),
        .dispatch_src2_vld_i     (dispatch_src2_vld_i),
        .dispatch_rrf_tag_i      (dispatch_rrf_tag_i),
        .dispatch_if_write_rrf_i (dispatch_if_write_rrf_i),
        .fwd0_vld_i              (fwd0_vld_i),
        .fwd0_tag_i              (fwd0_tag_i),
        .fwd0_data_i             (fwd0_data_i),
        .fwd1_vld_i              (fwd1_vld_i),
        .fwd1_tag_i              (fwd1_tag_i),
        .fwd1_data_i             (fwd1_data_i),
        .full_o                  (full_o),
        .busy_cnt_o              (busy_cnt_o),
        .issue_o                 (issue_o),
        .alu_op_o                (alu_op_o),
        .src1_o                  (src1_o),
        .src2_o                  (src2_o),
        .rrf_tag_o               (rrf_tag_o),
        .if_write_rrf_o          (if_write_rrf_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- behavioural model: a table of waiting ops ----------------
    bit          m_busy [8];
    logic [3:0]  m_op   [8];
    logic        m_v1   [8];
    logic [31:0] m_d1   [8];
    logic        m_v2   [8];
    logic [31:0] m_d2   [8];
    logic [5:0]  m_tag  [8];
    logic        m_wr   [8];
    logic        e_issue = 1'b0;
    logic [3:0]  e_op = '0;
    logic [31:0] e_s1 = '0, e_s2 = '0;
    logic [5:0]  e_tag = '0;
    logic        e_wr = 1'b0;
    int          m_pick, m_slot, m_cnt;

    function automatic logic [32:0] wake(input logic v, input logic [31:0] d);
        if (!v && fwd0_vld_i && fwd0_tag_i == d[5:0]) return {1'b1, fwd0_data_i};
        if (!v && fwd1_vld_i && fwd1_tag_i == d[5:0]) return {1'b1, fwd1_data_i};
        return {v, d};
    endfunction

    task automatic model_step();
        if (!reset_i || kill_i) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
            e_issue = 1'b0;
        end else begin
            m_pick = -1;
            m_slot = -1;
            for (int i = 0; i < 8; i++) begin
                if (m_pick < 0 && m_busy[i] && m_v1[i] && m_v2[i]) m_pick = i;
                if (m_slot < 0 && !m_busy[i]) m_slot = i;
            end
            for (int i = 0; i < 8; i++) begin
                if (m_busy[i]) begin
                    {m_v1[i], m_d1[i]} = wake(m_v1[i], m_d1[i]);
                    {m_v2[i], m_d2[i]} = wake(m_v2[i], m_d2[i]);
                end
            end
            e_issue = (m_pick >= 0);
            if (m_pick >= 0) begin
                e_op  = m_op[m_pick];
                e_s1  = m_d1[m_pick];
                e_s2  = m_d2[m_pick];
                e_tag = m_tag[m_pick];
                e_wr  = m_wr[m_pick];
                m_busy[m_pick] = 1'b0;
            end
            if (dispatch_we_i && m_slot >= 0) begin
                m_busy[m_slot] = 1'b1;
                m_op[m_slot]   = dispatch_alu_op_i;
                m_tag[m_slot]  = dispatch_rrf_tag_i;
                m_wr[m_slot]   = dispatch_if_write_rrf_i;
                {m_v1[m_slot], m_d1[m_slot]} = wake(dispatch_src1_vld_i, dispatch_src1_i);
                {m_v2[m_slot], m_d2[m_slot]} = wake(dispatch_src2_vld_i, dispatch_src2_i);
            end
        end
    endtask

    initial forever begin
        @(posedge clk_i or negedge reset_i);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_issue"},   32'(issue_o), 0);
        check({pfx, "_op"},      32'(alu_op_o), 0);
        check({pfx, "_src1"},    src1_o, 0);
        check({pfx, "_src2"},    src2_o, 0);
        check({pfx, "_tag"},     32'(rrf_tag_o), 0);
        check({pfx, "_wr"},      32'(if_write_rrf_o), 0);
        check({pfx, "_full"},    32'(full_o), 0);
        check({pfx, "_cnt"},     32'(busy_cnt_o), 0);
    endtask

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk_i);
        if (!reset_i) begin
            check_zero_outputs("cyc_rst");
        end else begin
            m_cnt = 0;
            for (int i = 0; i < 8; i++) m_cnt += int'(m_busy[i]);
            check("cyc_issue", 32'(issue_o), 32'(e_issue));
            check("cyc_busy_cnt", 32'(busy_cnt_o), 32'(m_cnt));
            check("cyc_full", 32'(full_o), 32'(m_cnt == 8));
            if (e_issue) begin
                check("cyc_op",   32'(alu_op_o), 32'(e_op));
                check("cyc_src1", src1_o, e_s1);
                check("cyc_src2", src2_o, e_s2);
                check("cyc_tag",  32'(rrf_tag_o), 32'(e_tag));
                check("cyc_wr",   32'(if_write_rrf_o), 32'(e_wr));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr_in();
        kill_i = 0; dispatch_we_i = 0; dispatch_alu_op_i = '0;
        dispatch_src1_i = '0; dispatch_src1_vld_i = 0;
        dispatch_src2_i = '0; dispatch_src2_vld_i = 0;
        dispatch_rrf_tag_i = '0; dispatch_if_write_rrf_i = 0;
        fwd0_vld_i = 0; fwd0_tag_i = '0; fwd0_data_i = '0;
        fwd1_vld_i = 0; fwd1_tag_i = '0; fwd1_data_i = '0;
    endtask

    task automatic tick();
        @(negedge clk_i);
        clr_in();
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] s1, input logic v1,
                        input logic [31:0] s2, input logic v2, input logic [5:0] tag,
                        input logic wr);
        dispatch_we_i = 1; dispatch_alu_op_i = op;
        dispatch_src1_i = s1; dispatch_src1_vld_i = v1;
        dispatch_src2_i = s2; dispatch_src2_vld_i = v2;
        dispatch_rrf_tag_i = tag; dispatch_if_write_rrf_i = wr;
        $display("dispatch op=%0d src1=0x%0h/%0b src2=0x%0h/%0b tag=%0d", op, s1, v1, s2, v2, tag);
    endtask

    task automatic fwd0(input logic [5:0] tag, input logic [31:0] data);
        fwd0_vld_i = 1; fwd0_tag_i = tag; fwd0_data_i = data;
    endtask

    task automatic fwd1(input logic [5:0] tag, input logic [31:0] data);
        fwd1_vld_i = 1; fwd1_tag_i = tag; fwd1_data_i = data;
    endtask

    initial begin
        clr_in();
        reset_i = 0;
        tick(); tick();
        check_zero_outputs("init_rst");
        reset_i = 1;
        tick();

        // Ready dispatch: issue two cycles later.
        tick(); disp(4'(ALU_OP_ADD), 32'd5, 1, 32'd7, 1, 6'd3, 1);
        tick(); check("t1_n1_issue", 32'(issue_o), 0); check("t1_n1_cnt", 32'(busy_cnt_o), 1);
        tick(); check("t1_issue", 32'(issue_o), 1); check("t1_src1", src1_o, 5);
        check("t1_src2", src2_o, 7); check("t1_tag", 32'(rrf_tag_o), 3);
        check("t1_op", 32'(alu_op_o), 0); check("t1_cnt", 32'(busy_cnt_o), 0);

        // Wakeup on bus 0; non-matching tag first.
        tick(); disp(4'(ALU_OP_SUB), 32'd1, 1, 32'd9, 0, 6'd10, 1);
        tick(); fwd0(6'd8, 32'h5555);
        tick(); check("t2_nomatch_a", 32'(issue_o), 0);
        tick(); check("t2_nomatch_b", 32'(issue_o), 0); check("t2_cnt", 32'(busy_cnt_o), 1);
        fwd0(6'd9, 32'h1234);
        tick(); check("t2_m1_issue", 32'(issue_o), 0);
        tick(); check("t2_issue", 32'(issue_o), 1); check("t2_src2", src2_o, 32'h1234);
        check("t2_src1", src1_o, 1); check("t2_tag", 32'(rrf_tag_o), 10);

        // Dispatch-cycle bypass from bus 1.
        tick(); disp(4'(ALU_OP_AND), 32'd4, 0, 32'd2, 1, 6'd5, 0); fwd1(6'd4, 32'hAA);
        tick(); check("t3_n1_issue", 32'(issue_o), 0);
        tick(); check("t3_issue", 32'(issue_o), 1); check("t3_src1", src1_o, 32'hAA);
        check("t3_src2", src2_o, 2); check("t3_wr", 32'(if_write_rrf_o), 0);

        // Fill all entries with waiting ops, try a ninth, then wake entry 2.
        for (int i = 0; i < 8; i++) begin
            tick(); disp(4'(ALU_OP_OR), 32'(16 + i), 0, 32'(i), 1, 6'(i), 1);
        end
        tick(); check("t4_full", 32'(full_o), 1); check("t4_cnt8", 32'(busy_cnt_o), 8);
        disp(4'(ALU_OP_XOR), 32'd1, 1, 32'd2, 1, 6'd40, 1);
        tick(); check("t4_ignored_cnt", 32'(busy_cnt_o), 8);
        tick(); check("t4_ignored_issue", 32'(issue_o), 0);
        fwd0(6'd18, 32'h77);
        tick(); check("t4_m1_issue", 32'(issue_o), 0);
        tick(); check("t4_issue", 32'(issue_o), 1); check("t4_src1", src1_o, 32'h77);
        check("t4_tag", 32'(rrf_tag_o), 2); check("t4_cnt7", 32'(busy_cnt_o), 7);
        check("t4_not_full", 32'(full_o), 0);
        kill_i = 1;
        tick(); check("t4_kill_cnt", 32'(busy_cnt_o), 0); check("t4_kill_issue", 32'(issue_o), 0);

        // Three entries become ready together; kill during the second issue.
        for (int i = 0; i < 3; i++) begin
            tick(); disp(4'(ALU_OP_ADD), 32'd20, 0, 32'(16 + i), 1, 6'(1 + i), 1);
        end
        tick(); fwd0(6'd20, 32'h100);
        tick(); check("t5_m1_issue", 32'(issue_o), 0);
        tick(); check("t5_first", 32'(issue_o), 1); check("t5_first_tag", 32'(rrf_tag_o), 1);
        check("t5_first_src1", src1_o, 32'h100); check("t5_first_src2", src2_o, 32'h10);
        tick(); check("t5_second", 32'(issue_o), 1); check("t5_second_tag", 32'(rrf_tag_o), 2);
        check("t5_second_src2", src2_o, 32'h11);
        kill_i = 1;
        tick(); check("t5_kill_issue", 32'(issue_o), 0); check("t5_kill_cnt", 32'(busy_cnt_o), 0);

        // Asynchronous reset while three ops wait and one is issuing.
        for (int i = 0; i < 3; i++) begin
            tick(); disp(4'(ALU_OP_SLT), 32'(30 + i), 0, 32'd0, 1, 6'(i), 1);
        end
        tick(); disp(4'(ALU_OP_SUB), 32'h55, 1, 32'h66, 1, 6'd7, 1);
        tick();
        tick(); check("t6_pre_issue", 32'(issue_o), 1); check("t6_pre_src1", src1_o, 32'h55);
        check("t6_pre_cnt", 32'(busy_cnt_o), 3);
        #2 reset_i = 0;
        #1 check_zero_outputs("t6_async_rst");
        tick(); tick();
        reset_i = 1;
        tick(); check("t6_post_cnt", 32'(busy_cnt_o), 0); check("t6_post_issue", 32'(issue_o), 0);
        tick(); check("t6_post_issue2", 32'(issue_o), 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station directly upstream of the ALU execute stage.
- Holds dispatched ALU ops until both source operands are valid, then issues one op per cycle to the execute stage.
- Issue bundle is registered: op, src1, src2, rrf tag, write-rrf flag, issue strobe.
- Captures operands from two result-forwarding buses: bus 0 is the ALU execute stage's own registered result; bus 1 is another unit's result.

Parameters:
ENTRY_NUM, 8, number of entries (power of two)
ENTRY_SEL, 3, log2(ENTRY_NUM)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset (0 = reset)
kill_i  in  1  pipeline flush; clears all entries and the issue register
dispatch_we_i  in  1  write one new entry this cycle
dispatch_alu_op_i  in  ALU_OP_WIDTH  ALU opcode
dispatch_src1_i  in  DATA_LEN  value, or producing rrf tag in low RRF_SEL bits when invalid
dispatch_src1_vld_i  in  1  src1 holds a value
dispatch_src2_i  in  DATA_LEN  as src1
dispatch_src2_vld_i  in  1  as src1
dispatch_rrf_tag_i  in  RRF_SEL  destination rename tag
dispatch_if_write_rrf_i  in  1  op writes a rename register
fwd0_vld_i, fwd1_vld_i  in  1  forwarding bus valid
fwd0_tag_i, fwd1_tag_i  in  RRF_SEL  forwarded tag
fwd0_data_i, fwd1_data_i  in  DATA_LEN  forwarded value
full_o  out  1  all entries busy
busy_cnt_o  out  ENTRY_SEL+1  occupied entry count
issue_o  out  1  issue strobe to execute stage
alu_op_o  out  ALU_OP_WIDTH  issued opcode
src1_o, src2_o  out  DATA_LEN  issued operands
rrf_tag_o  out  RRF_SEL  issued destination tag
if_write_rrf_o  out  1  issued write-rrf flag

Behaviour:
Reset:
- reset_i low asynchronously clears all entry valid bits and the issue register.
- While in reset: issue_o=0, alu_op_o=0, src1_o=0, src2_o=0, rrf_tag_o=0, if_write_rrf_o=0, full_o=0, busy_cnt_o=0.
- Reset mid-operation discards all held ops; no partial issue.

Entry state:
- Each entry holds: busy, op, src1/src1_vld, src2/src2_vld, rrf_tag, if_write_rrf.

Allocation:
- Dispatch writes the lowest-index non-busy entry.
- full_o and busy_cnt_o are derived from registered busy bits only.
- dispatch_we_i while full_o=1 is ignored; the dispatcher must not do this.
- An entry freed by issue this cycle is not reusable until the next cycle.

Wakeup:
- For each busy entry and each invalid operand, if fwdN_vld_i and fwdN_tag_i == operand[RRF_SEL-1:0], latch fwdN_data_i and set vld.
- Bus 0 wins if both buses match the same operand; legal tags make this impossible.
- Dispatch-time bypass: an operand dispatched invalid whose tag matches a forwarding bus in the same cycle is written valid with the forwarded data.

Select and issue:
- Ready = busy & src1_vld & src2_vld, from registered state.
- Lowest-index ready entry is selected.
- Its fields load the issue register at the clock edge; issue_o=1 the next cycle, and the entry's busy bit clears at that same edge.
- No ready entry gives issue_o=0; other issue fields hold their previous values.

Latency:
- Dispatch with both operands valid in cycle N gives issue_o=1 in N+2.
- Operand woken in cycle N (entry already busy) gives issue_o=1 in N+2.
- A newly dispatched entry is never selected in its dispatch cycle.

Throughput:
- One issue per cycle; the execute stage never stalls, so there is no backpressure.

Kill:
- Synchronous; highest priority.
- Clears all busy bits and issue_o at the next edge; dispatch and wakeup that cycle are dropped.

Simultaneous events:
- Dispatch, wakeup of other entries, and issue of a third entry in one cycle all take effect independently.
- busy_cnt_o next = busy_cnt_o + dispatch accepted − issued.

Decomposition:
- Shared constants header already carries DATA_LEN, RRF_SEL and ALU_OP_WIDTH; add RS_ALU_ENTRY_NUM and RS_ALU_ENTRY_SEL there.
- Sub-module prio_enc_lsb (parameterised lowest-set-bit priority encoder with valid output).
- prio_enc_lsb is instantiated twice: once for free-entry allocation, once for ready selection.

Test Plan:
- Reset: reset_i=0 mid-run with 3 busy entries -> all outputs 0 immediately; after release busy_cnt_o=0, issue_o=0.
- Ready dispatch: op=ADD, src1=5 vld, src2=7 vld, tag=3 in cycle N -> issue_o=1 in N+2 with src1_o=5, src2_o=7, rrf_tag_o=3; busy_cnt_o back to 0.
- Wakeup: dispatch src2 invalid with tag 9, then fwd0_vld_i=1, tag 9, data 0x1234 in cycle M -> issue in M+2 with src2_o=0x1234; a non-matching tag 8 causes no issue.
- Dispatch bypass: dispatch src1 invalid tag 4 while fwd1 carries tag 4, data 0xAA in the same cycle -> issue two cycles later with src1_o=0xAA.
- Full: fill 8 non-ready entries -> full_o=1, busy_cnt_o=8; a 9th dispatch is ignored; waking entry 2 gives one issue, then full_o=0.
- Kill and priority: 3 ready entries at indices 0, 1, 2 issue in index order on consecutive cycles; kill_i in the second issue cycle -> next cycle issue_o=0, busy_cnt_o=0.
